// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the ARM-subset datapath.
// master is the controller side; slave is the datapath side.
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control unit for the ARM-subset datapath: sequences fetch/decode/execute,
// holds NZCV flags and evaluates condition codes to gate every architectural write.
module multicycle_controller (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e     state_q;
  logic       cond_ok_q;
  logic [3:0] flags_q;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       rd_is_pc;
  logic [1:0] ex_alu_ctrl;
  logic       ex_writeback;
  logic       ex_is_cmp;
  logic       flag_update;
  logic       cond_now;

  assign op       = bus.Instr[27:26];
  assign funct    = bus.Instr[25:20];
  assign cmd      = funct[4:1];
  assign rd_is_pc = (bus.Instr[15:12] == 4'd15);

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = cf;
      4'h3:    cond_eval = !cf;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = cf && !z;
      4'h9:    cond_eval = !cf || z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z && (n == v);
      4'hD:    cond_eval = z || (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign cond_now = cond_eval(bus.Instr[31:28], flags_q);

  // Data-processing decode; unsupported commands compute ADD but never write back.
  always_comb begin
    ex_alu_ctrl  = 2'b00;
    ex_writeback = 1'b1;
    ex_is_cmp    = 1'b0;
    case (cmd)
      4'b0100: ex_alu_ctrl = 2'b00;
      4'b0010: ex_alu_ctrl = 2'b01;
      4'b0000: ex_alu_ctrl = 2'b10;
      4'b1100: ex_alu_ctrl = 2'b11;
      4'b1010: begin
        ex_alu_ctrl  = 2'b01;
        ex_writeback = 1'b0;
        ex_is_cmp    = 1'b1;
      end
      default: ex_writeback = 1'b0;
    endcase
  end

  assign flag_update = (state_q == StExecR || state_q == StExecI) && cond_ok_q &&
                       (funct[0] || ex_is_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      cond_ok_q <= 1'b0;
      flags_q   <= 4'b0000;
    end else begin
      if (flag_update) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        // C and V are only meaningful for the adder/subtractor.
        if (!ex_alu_ctrl[1]) flags_q[1:0] <= bus.ALUFlags[1:0];
      end
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          cond_ok_q <= cond_now;
          case (op)
            2'b01:   state_q <= StMemAdr;
            2'b00:   state_q <= funct[5] ? StExecI : StExecR;
            2'b10:   state_q <= StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= funct[0] ? StMemRd : StMemWr;
        StMemRd:  state_q <= StMemWb;
        StExecR,
        StExecI:  state_q <= ex_writeback ? StAluWb : StFetch;
        default:  state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.ImmSrc     = op;
    bus.RegSrc     = {op == 2'b01, op == 2'b10};
    bus.State      = state_q;
    case (state_q)
      StFetch: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
      end
      StDecode: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      StMemAdr: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = funct[3] ? 2'b00 : 2'b01;
      end
      StMemRd: bus.AdrSrc = 1'b1;
      StMemWb: begin
        bus.ResultSrc = 2'b01;
        bus.PCWrite   = cond_ok_q && rd_is_pc;
        bus.RegWrite  = cond_ok_q && !rd_is_pc;
      end
      StMemWr: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = cond_ok_q;
      end
      StExecR: bus.ALUControl = ex_alu_ctrl;
      StExecI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = ex_alu_ctrl;
      end
      StAluWb: begin
        bus.PCWrite  = cond_ok_q && rd_is_pc;
        bus.RegWrite = cond_ok_q && !rd_is_pc;
      end
      StBranch: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = cond_ok_q;
      end
      default: ;
    endcase
    // Reset abandons the instruction at once, without waiting for an edge.
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a per-instruction reference model pushes the expected per-cycle control
// vector; a negedge monitor pops and compares against the controller's outputs.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aluc;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic       regw;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  rec_t sb[$];
  logic [3:0] mflags;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t sample();
    rec_t r;
    r.st   = bus.State;
    r.pcw  = bus.PCWrite;
    r.adr  = bus.AdrSrc;
    r.memw = bus.MemWrite;
    r.irw  = bus.IRWrite;
    r.res  = bus.ResultSrc;
    r.asa  = bus.ALUSrcA;
    r.asb  = bus.ALUSrcB;
    r.aluc = bus.ALUControl;
    r.imm  = bus.ImmSrc;
    r.rsrc = bus.RegSrc;
    r.regw = bus.RegWrite;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
      else begin
        rec_t e;
        e = sb.pop_front();
        check("cycle_ctrl", 32'(sample()), 32'(e));
      end
    end
  end

  // Conditions come in complementary pairs: even code is the base test, odd code its inverse.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  function automatic rec_t mk(input logic [31:0] instr, input int st, input logic pcw,
                              input logic adr, input logic memw, input logic irw,
                              input int res, input logic asa, input int asb, input int aluc,
                              input logic regw);
    rec_t r;
    r.st   = 4'(st);
    r.pcw  = pcw;
    r.adr  = adr;
    r.memw = memw;
    r.irw  = irw;
    r.res  = 2'(res);
    r.asa  = asa;
    r.asb  = 2'(asb);
    r.aluc = 2'(aluc);
    r.imm  = instr[27:26];
    r.rsrc = {instr[27:26] == 2'b01, instr[27:26] == 2'b10};
    r.regw = regw;
    return r;
  endfunction

  // Model one instruction, drive it, and wait out its cycles.
  task automatic issue(input logic [31:0] instr, input logic [3:0] af);
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] cmd;
    logic       ok, pc, wb;
    int         alu, n;
    op  = instr[27:26];
    fn  = instr[25:20];
    cmd = fn[4:1];
    pc  = (instr[15:12] == 4'hF);
    ok  = cond_holds(instr[31:28], mflags);
    n   = 2;
    sb.push_back(mk(instr, 0, 1, 0, 0, 1, 2, 1, 2, 0, 0));
    sb.push_back(mk(instr, 1, 0, 0, 0, 0, 2, 1, 2, 0, 0));
    if (op == 2'b01) begin
      sb.push_back(mk(instr, 2, 0, 0, 0, 0, 0, 0, 1, fn[3] ? 0 : 1, 0));
      if (fn[0]) begin
        sb.push_back(mk(instr, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(instr, 4, ok & pc, 0, 0, 0, 1, 0, 0, 0, ok & ~pc));
        n += 3;
      end else begin
        sb.push_back(mk(instr, 5, 0, 1, ok, 0, 0, 0, 0, 0, 0));
        n += 2;
      end
    end else if (op == 2'b00) begin
      wb = 1'b1;
      case (cmd)
        4'b0100: alu = 0;
        4'b0010: alu = 1;
        4'b0000: alu = 2;
        4'b1100: alu = 3;
        4'b1010: begin alu = 1; wb = 1'b0; end
        default: begin alu = 0; wb = 1'b0; end
      endcase
      sb.push_back(mk(instr, fn[5] ? 7 : 6, 0, 0, 0, 0, 0, 0, fn[5] ? 1 : 0, alu, 0));
      n++;
      if (ok && (fn[0] || cmd == 4'b1010)) begin
        mflags[3:2] = af[3:2];
        if (alu < 2) mflags[1:0] = af[1:0];
      end
      if (wb) begin
        sb.push_back(mk(instr, 8, ok & pc, 0, 0, 0, 0, 0, 0, 0, ok & ~pc));
        n++;
      end
    end else if (op == 2'b10) begin
      sb.push_back(mk(instr, 9, ok, 0, 0, 0, 2, 0, 1, 0, 0));
      n++;
    end
    bus.Instr    = instr;
    bus.ALUFlags = af;
    mon_en       = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("flags", 32'(dut.flags_q), 32'(mflags));
  endtask

  initial begin
    reset        = 1'b1;
    bus.Instr    = 32'h0;
    bus.ALUFlags = 4'h0;
    mflags       = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.State), 32'd0);
    check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    check("rst_flags", 32'(dut.flags_q), 32'd0);
    check("rst_cond_ok", 32'(dut.cond_ok_q), 32'd0);
    reset = 1'b0;

    issue(32'hE0821003, 4'h0);  // ADD
    issue(32'hE5921004, 4'h0);  // LDR
    issue(32'hE5821004, 4'h0);  // STR
    issue(32'hE0500000, 4'h4);  // SUBS -> Z
    issue(32'h0A000002, 4'h0);  // BEQ taken
    issue(32'h1A000002, 4'h0);  // BNE not taken
    issue(32'hE1500001, 4'h8);  // CMP -> N
    issue(32'hE0500000, 4'h4);  // SUBS -> Z again
    issue(32'h12821005, 4'h0);  // ADDNE suppressed
    issue(32'hE082F003, 4'h0);  // ADD to PC
    issue(32'hEC000000, 4'h0);  // illegal Op=11

    // Abort a store in its MEMWR cycle.
    mon_en       = 1'b0;
    bus.Instr    = 32'hE5821004;
    repeat (3) @(posedge clk);
    #2;
    check("abort_pre_state", 32'(bus.State), 32'd5);
    check("abort_pre_memw", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_state", 32'(bus.State), 32'd0);
    check("abort_memw", 32'(bus.MemWrite), 32'd0);
    check("abort_pcw", 32'(bus.PCWrite), 32'd0);
    check("abort_flags", 32'(dut.flags_q), 32'd0);
    mflags = 4'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
      issue(ins, 4'($urandom_range(0, 15)));
    end

    mon_en = 1'b0;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
